// File: rtl/logic_design_pkg.sv
// Shared widths and seven-segment glyph table for the accumulator display.
package logic_design_pkg;

    localparam int ACC_W = 8;
    localparam int NIB_W = 4;
    localparam int SEG_W = 7;

    typedef logic [SEG_W-1:0] seg_t;

    // Active-low segments, bit0=a .. bit6=g
    localparam seg_t SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/logic_design_hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
    import logic_design_pkg::*;
(
    input  logic [NIB_W-1:0] val_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = SEG_GLYPH[val_i];

endmodule

// File: rtl/logic_design_top.sv
// 8-bit wrapping accumulator of SW[3:0], shown on HEX1:HEX0; HEX3 shows SW[3:0].
module logic_design_top
    import logic_design_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic [4:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX3
);

    logic             rst_n;
    logic [NIB_W-1:0] operand;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    assign rst_n   = SW[4];
    assign operand = SW[NIB_W-1:0];

    // Carry out of bit 7 is intentionally dropped
    assign acc_d = acc_q + ACC_W'(operand);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    hex7seg u_hex0 (
        .val_i (acc_q[NIB_W-1:0]),
        .seg_o (HEX0)
    );

    hex7seg u_hex1 (
        .val_i (acc_q[ACC_W-1:NIB_W]),
        .seg_o (HEX1)
    );

    hex7seg u_hex3 (
        .val_i (operand),
        .seg_o (HEX3)
    );

endmodule

// File: tb/tb_logic_design_top.sv
// Self-checking bench: glyph table vectors, directed corner sequences, random run.
module tb_logic_design_top;

    logic       clk;
    logic [4:0] sw;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex3;

    int checks;
    int failures;
    int model_acc;

    typedef struct {
        logic [3:0] sw;
        logic [6:0] hex;
    } vec_t;

    vec_t tbl [16];

    logic [6:0] gly [16];

    logic_design_top dut (
        .CLOCK_50 (clk),
        .SW       (sw),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX3     (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%02h expected=0x%02h", name, got, exp);
        end
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_acc(input string name, input int a);
        chk({name, "_hex0"}, hex0, gly[a % 16]);
        chk({name, "_hex1"}, hex1, gly[(a / 16) % 16]);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sw       = 5'b00011;

        tbl[0]  = '{4'h0, 7'h40};
        tbl[1]  = '{4'h1, 7'h79};
        tbl[2]  = '{4'h2, 7'h24};
        tbl[3]  = '{4'h3, 7'h30};
        tbl[4]  = '{4'h4, 7'h19};
        tbl[5]  = '{4'h5, 7'h12};
        tbl[6]  = '{4'h6, 7'h02};
        tbl[7]  = '{4'h7, 7'h78};
        tbl[8]  = '{4'h8, 7'h00};
        tbl[9]  = '{4'h9, 7'h10};
        tbl[10] = '{4'hA, 7'h08};
        tbl[11] = '{4'hB, 7'h03};
        tbl[12] = '{4'hC, 7'h46};
        tbl[13] = '{4'hD, 7'h21};
        tbl[14] = '{4'hE, 7'h06};
        tbl[15] = '{4'hF, 7'h0E};
        for (int i = 0; i < 16; i++) gly[tbl[i].sw] = tbl[i].hex;

        // Reset with clock running
        #1;
        edges(3);
        chk("rst_hex0", hex0, 7'h40);
        chk("rst_hex1", hex1, 7'h40);
        chk("rst_hex3", hex3, 7'h30);

        // Decoder sweep under reset
        for (int i = 0; i < 16; i++) begin
            sw = {1'b0, tbl[i].sw};
            #1;
            chk($sformatf("sweep_hex3_%0d", i), hex3, tbl[i].hex);
            chk($sformatf("sweep_hex0_%0d", i), hex0, 7'h40);
        end

        // Accumulate 3 x 3
        @(posedge clk);
        #1;
        sw = 5'b10011;
        edges(3);
        chk("acc9_hex0", hex0, 7'h10);
        chk("acc9_hex1", hex1, 7'h40);
        chk("acc9_hex3", hex3, 7'h30);

        // Wrap 0xFE + 5 -> 0x03
        sw = 5'b00000;
        #1;
        sw = 5'b11111;
        edges(16);
        sw = 5'b11110;
        edges(1);
        chk_acc("pre_wrap", 8'hFE);
        sw = 5'b10101;
        edges(1);
        chk("wrap_hex0", hex0, 7'h30);
        chk("wrap_hex1", hex1, 7'h40);

        // Async reset from 0x2A between edges
        sw = 5'b00000;
        #1;
        sw = 5'b11111;
        edges(2);
        sw = 5'b11100;
        edges(1);
        chk_acc("acc2a", 8'h2A);
        #2;
        sw = 5'b00111;
        #1;
        chk("async_hex0", hex0, 7'h40);
        chk("async_hex1", hex1, 7'h40);
        edges(3);
        chk("async_hold_hex0", hex0, 7'h40);
        chk("async_hold_hex1", hex1, 7'h40);

        // Hold at 0x5C with zero operand
        sw = 5'b11111;
        edges(6);
        sw = 5'b10010;
        edges(1);
        sw = 5'b10000;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk($sformatf("hold_hex1_%0d", i), hex1, 7'h12);
            chk($sformatf("hold_hex0_%0d", i), hex0, 7'h46);
        end

        // Random run against arithmetic model
        sw = 5'b00000;
        #1;
        model_acc = 0;
        for (int i = 0; i < 400; i++) begin
            sw = 5'($urandom);
            if ($urandom_range(0, 15) != 0) sw[4] = 1'b1;
            #1;
            if (!sw[4]) model_acc = 0;
            chk("rnd_pre_hex3", hex3, gly[sw[3:0]]);
            chk_acc("rnd_pre", model_acc);
            @(posedge clk);
            if (sw[4]) model_acc = (model_acc + int'(sw[3:0])) % 256;
            #1;
            chk_acc("rnd_post", model_acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
